// File: rtl/hpdl_pkg.sv
// Shared types and character constants for the HPDL-1414 display refresh controller.
// The helper maps raw buffer bytes onto the device's printable range.
package hpdl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD
  } state_e;

  typedef enum logic [1:0] {
    WP_OFF,
    WP_SETUP,
    WP_PULSE,
    WP_HOLD
  } wr_phase_e;

  localparam logic [7:0]  CHAR_SPACE = 8'h20;
  localparam logic [7:0]  CHAR_MIN   = 8'h20;
  localparam logic [7:0]  CHAR_MAX   = 8'h5F;
  localparam int unsigned NUM_CHARS  = 16;
  localparam int unsigned IDX_W      = 4;

  // Anything the HPDL-1414 cannot render (including bytes with bit 7 set) becomes a blank.
  function automatic logic [6:0] to_hpdl_char(input logic [7:0] raw);
    logic [7:0] c;
    c = ((raw >= CHAR_MIN) && (raw <= CHAR_MAX)) ? raw : CHAR_SPACE;
    return c[6:0];
  endfunction

endpackage

// File: rtl/hpdl_write_timer.sv
// Setup / pulse / hold phase sequencer for one HPDL-1414 write cycle.
// Each phase is a down-counter loaded with (length-1); the phase ends on terminal count zero.
module hpdl_write_timer
  import hpdl_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic      i_clk,
  input  logic      i_reset,
  input  logic      start,
  output wr_phase_e phase,
  output logic      last,
  output logic      done
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned SETUP_N = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
  localparam int unsigned PULSE_N = (PULSE_CYC < 1) ? 1 : PULSE_CYC;
  localparam int unsigned HOLD_N  = (HOLD_CYC  < 1) ? 1 : HOLD_CYC;

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_N - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_N - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_N - 1);

  wr_phase_e        phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc;

  assign tc = (cnt_q == '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      phase_q <= WP_OFF;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    case (phase_q)
      WP_OFF: begin
        if (start) begin
          phase_d = WP_SETUP;
          cnt_d   = SETUP_LOAD;
        end
      end
      WP_SETUP: begin
        if (tc) begin
          phase_d = WP_PULSE;
          cnt_d   = PULSE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WP_PULSE: begin
        if (tc) begin
          phase_d = WP_HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WP_HOLD: begin
        if (tc) begin
          phase_d = WP_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        phase_d = WP_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  assign phase = phase_q;
  assign last  = (phase_q != WP_OFF) && tc;
  assign done  = (phase_q == WP_HOLD) && tc;

endmodule

// File: rtl/display_refresh_ctrl.sv
// Periodically copies a 16-character buffer onto four HPDL-1414 displays and
// generates the caret blink phase for the buffer.
//
//   state      | meaning
//   IDLE       | waiting for a pending refresh request
//   READ       | o_rd_en high for the current character index
//   CAPTURE    | buffer data valid; sanitise and register it, start write timer
//   SETUP      | address/data on the bus, strobes high
//   PULSE      | selected device strobe low
//   HOLD       | strobe high again, bus held; then next char or frame done
module display_refresh_ctrl
  import hpdl_pkg::*;
#(
  parameter int unsigned REFRESH_TICKS = 12000,
  parameter int unsigned BLINK_TICKS   = 3000000,
  parameter int unsigned SETUP_CYC     = 1,
  parameter int unsigned PULSE_CYC     = 2,
  parameter int unsigned HOLD_CYC      = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_kick,
  output logic       o_rd_en,
  output logic [3:0] o_rd_addr,
  input  logic [7:0] i_rd_data,
  output logic       o_caret_strobe,
  output logic [6:0] o_hpdl_data,
  output logic [1:0] o_hpdl_addr,
  output logic [3:0] o_hpdl_wr_n,
  output logic       o_busy,
  output logic       o_frame_done
);

  localparam int unsigned REF_N   = (REFRESH_TICKS < 1) ? 1 : REFRESH_TICKS;
  localparam int unsigned BLINK_N = (BLINK_TICKS < 1) ? 1 : BLINK_TICKS;
  localparam int unsigned REF_W   = (REF_N > 1) ? $clog2(REF_N) : 1;
  localparam int unsigned BLINK_W = (BLINK_N > 1) ? $clog2(BLINK_N) : 1;

  localparam logic [REF_W-1:0]   REF_LAST   = REF_W'(REF_N - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_N - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_CHARS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   index;
  logic               pending;
  logic [REF_W-1:0]   ref_cnt;
  logic               ref_tick;
  logic [BLINK_W-1:0] blink_cnt;
  logic               caret;
  logic [6:0]         char_data;
  logic [1:0]         digit;
  logic [3:0]         wr_n;
  logic               frame_done;
  logic               frame_last;
  logic [3:0]         dev_sel;

  wr_phase_e          tmr_phase;
  logic               tmr_start;
  logic               tmr_last;
  logic               tmr_done;

  hpdl_write_timer #(
    .SETUP_CYC (SETUP_CYC),
    .PULSE_CYC (PULSE_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) u_write_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .start   (tmr_start),
    .phase   (tmr_phase),
    .last    (tmr_last),
    .done    (tmr_done)
  );

  assign ref_tick = (ref_cnt == REF_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset || ref_tick) begin
      ref_cnt <= '0;
    end else begin
      ref_cnt <= ref_cnt + REF_W'(1);
    end
  end

  // Caret phase is purely time based so the blink rate never depends on frame activity.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      blink_cnt <= '0;
      caret     <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      caret     <= ~caret;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // Taking the pending flag has priority, so a request in the same cycle folds into this frame.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pending <= 1'b0;
    end else if ((state_q == ST_IDLE) && pending) begin
      pending <= 1'b0;
    end else if (i_kick || ref_tick) begin
      pending <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    o_rd_en   = 1'b0;
    tmr_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending) state_d = ST_READ;
      end
      ST_READ: begin
        o_rd_en = 1'b1;
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        tmr_start = 1'b1;
        state_d   = ST_SETUP;
      end
      ST_SETUP: begin
        if ((tmr_phase == WP_SETUP) && tmr_last) state_d = ST_PULSE;
      end
      ST_PULSE: begin
        if ((tmr_phase == WP_PULSE) && tmr_last) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (tmr_done) state_d = (index == LAST_IDX) ? ST_IDLE : ST_READ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign frame_last = (state_q == ST_HOLD) && tmr_done && (index == LAST_IDX);
  assign dev_sel    = 4'b0001 << index[3:2];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      index      <= '0;
      char_data  <= '0;
      digit      <= '0;
      wr_n       <= 4'hF;
      frame_done <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_CAPTURE) begin
        char_data <= to_hpdl_char(i_rd_data);
        digit     <= ~index[1:0];
      end
      if ((state_q == ST_HOLD) && tmr_done) begin
        index <= (index == LAST_IDX) ? '0 : index + IDX_W'(1);
      end
      // Registered strobe: low exactly for the cycles spent in PULSE, glitch-free at the pins.
      wr_n       <= (state_d == ST_PULSE) ? ~dev_sel : 4'hF;
      frame_done <= frame_last;
    end
  end

  assign o_rd_addr      = index;
  assign o_caret_strobe = caret;
  assign o_hpdl_data    = char_data;
  assign o_hpdl_addr    = digit;
  assign o_hpdl_wr_n    = wr_n;
  assign o_busy         = (state_q != ST_IDLE);
  assign o_frame_done   = frame_done;

endmodule

// File: doc/display_refresh_ctrl.md
DISPLAY_REFRESH_CTRL -- requirements
Module: display_refresh_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_TICKS, default 12000, i_clk cycles between automatic frame starts.
REQ-002 SHALL have parameter BLINK_TICKS, default 3000000, i_clk cycles per o_caret_strobe half-period.
REQ-003 SHALL have parameter SETUP_CYC, default 1, address/data setup cycles before o_hpdl_wr_n falls.
REQ-004 SHALL have parameter PULSE_CYC, default 2, o_hpdl_wr_n low cycles.
REQ-005 SHALL have parameter HOLD_CYC, default 1, address/data hold cycles after o_hpdl_wr_n rises.
REQ-006 i_clk  in  1  system clock; all logic on rising edge.
REQ-007 i_reset  in  1  reset; synchronous, active-high.
REQ-008 i_kick  in  1  single-cycle request for an immediate frame.
REQ-009 o_rd_en  out  1  buffer read enable.
REQ-010 o_rd_addr  out  4  buffer read address, 0 = leftmost character.
REQ-011 i_rd_data  in  8  buffer read data, valid the cycle after o_rd_en.
REQ-012 o_caret_strobe  out  1  blink phase to the buffer; 1 = show character.
REQ-013 o_hpdl_data  out  7  HPDL-1414 D6..D0, shared bus.
REQ-014 o_hpdl_addr  out  2  HPDL-1414 A1..A0, shared bus.
REQ-015 o_hpdl_wr_n  out  4  per-device write strobes, active-low.
REQ-016 o_busy  out  1  high while a frame is in progress.
REQ-017 o_frame_done  out  1  single-cycle pulse after the last character's hold phase.

Function
REQ-018 Frame SHALL write characters 0..15 in ascending order, one full read/write sequence each.
REQ-019 States SHALL be IDLE, READ, CAPTURE, SETUP, PULSE, HOLD; READ asserts o_rd_en for exactly one cycle.
REQ-020 CAPTURE SHALL register i_rd_data one cycle after READ, then enter SETUP.
REQ-021 SETUP/PULSE/HOLD SHALL last SETUP_CYC/PULSE_CYC/HOLD_CYC cycles; each parameter is clamped to a minimum of 1.
REQ-022 After HOLD, index < 15 -> READ with index+1; index 15 -> IDLE with o_frame_done pulsed once.
REQ-023 Character i SHALL drive device i[3:2], digit address ~i[1:0]; e.g. index 0 -> device 0, digit 3.
REQ-024 Only the selected bit of o_hpdl_wr_n SHALL fall, and only during PULSE.
REQ-025 o_hpdl_data/o_hpdl_addr SHALL be stable from SETUP through HOLD.
REQ-026 Data outside 0x20..0x5F, including bit 7 set, SHALL be sent as 0x20.
REQ-027 The free-running refresh counter SHALL set a pending flag every REFRESH_TICKS cycles.
REQ-028 An i_kick pulse SHALL also set the pending flag.
REQ-029 In IDLE with pending set, READ SHALL be entered next cycle and pending cleared.
REQ-030 Requests during a frame SHALL merge into one pending flag: one following frame, never dropped, never doubled.
REQ-031 A request coinciding with frame start SHALL be absorbed into that frame.
REQ-032 Blink counter SHALL toggle o_caret_strobe every BLINK_TICKS cycles, independent of frame state.
REQ-033 o_busy SHALL be high in every state except IDLE.

Reset
REQ-034 On i_reset, state SHALL be IDLE, index 0, pending 0, both counters 0.
REQ-035 On i_reset, o_hpdl_wr_n SHALL be 4'b1111, o_rd_en 0, o_frame_done 0, o_busy 0.
REQ-036 On i_reset, o_caret_strobe SHALL be 1 and o_hpdl_data/o_hpdl_addr/o_rd_addr SHALL be 0.
REQ-037 Reset during PULSE SHALL raise the strobe on the next edge; the aborted frame is not resumed.

Structure
REQ-038 Package hpdl_pkg SHALL hold the state enumeration, CHAR_SPACE = 0x20, CHAR_MIN = 0x20, CHAR_MAX = 0x5F and NUM_CHARS = 16.
REQ-039 Sub-module hpdl_write_timer SHALL implement the SETUP/PULSE/HOLD phase counter, taking start and returning phase and done.

Verification
REQ-040 Buffer preloaded "TINY_TAPEOUT_10!", i_kick -> 16 writes; first write device 0, addr 3, data 0x54; last write device 3, addr 0, data 0x21; one o_frame_done.
REQ-041 SETUP/PULSE/HOLD = 2/3/1 -> each strobe low exactly 3 cycles; address/data unchanged for 2 cycles before and 1 after.
REQ-042 Buffer byte 0x7A at index 5 and 0x85 at index 6 -> device 1 receives 0x20 at addresses 2 and 1.
REQ-043 Three i_kick pulses during a frame -> exactly one additional frame, then IDLE.
REQ-044 i_reset asserted during PULSE of index 9 -> o_hpdl_wr_n = 1111 next edge; no write until next request; index restarts at 0.
REQ-045 BLINK_TICKS = 4 -> o_caret_strobe reads 1,1,1,1,0,0,0,0,1 from reset, unaffected by frames.
